muldiv_alu: RTL and testbench

- Iterative multiply/divide unit executing the RV32M operation set alongside the single-cycle integer ALU in the execute stage.
- XLEN is parametrised.
- Uses a radix-2 shift-add multiplier and a restoring divider, each taking XLEN iteration cycles.
- Operands enter and results leave through valid/ready handshakes, so the pipeline stalls only while this unit is busy.

---
 rtl/muldiv_pkg.sv | 44 ++++
 rtl/muldiv_signfix.sv | 70 +++++++
 rtl/muldiv_alu.sv | 209 ++++++++++++++++++++
 tb/tb_muldiv_alu.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared types and helpers for the RV32M iterative multiply/divide
//            unit: op-code enum (funct3 encoding), FSM state enum, op-class
//            helper and iteration-counter width.
// Revision : 1.0  initial release
// ============================================================================
package muldiv_pkg;

    // funct3 encoding of the M extension
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

    // Counter width for the default 32-bit configuration; instances with a
    // different XLEN size their counter through cnt_width().
    localparam int DEF_XLEN = 32;
    localparam int CNT_W    = $clog2(DEF_XLEN);

    function automatic int cnt_width(input int xlen);
        return $clog2(xlen);
    endfunction

    // Divide and remainder ops share the restoring-divider datapath.
    function automatic logic is_div(input muldiv_op_t op);
        return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_signfix.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_signfix
// Purpose  : Combinational sign handling for the multiply/divide unit.
//            Accept side: absolute operand values, operand signs and the
//            divide-by-zero flag for the incoming request.
//            Final side: sign correction of the raw magnitude result and
//            selection of the architectural field.
// Ports    : i_op/i_a/i_b          incoming request
//            o_abs_a/o_abs_b       operand magnitudes
//            o_sign_a/o_sign_b     operand treated as negative
//            o_div_zero            divide/remainder with zero divisor
//            i_fin_*               latched op, signs, zero flag, raw accumulator
//            o_fin_result          final XLEN-bit result
// Revision : 1.0  initial release
// ============================================================================
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  muldiv_op_t        i_op,
    input  logic [XLEN-1:0]   i_a,
    input  logic [XLEN-1:0]   i_b,
    output logic [XLEN-1:0]   o_abs_a,
    output logic [XLEN-1:0]   o_abs_b,
    output logic              o_sign_a,
    output logic              o_sign_b,
    output logic              o_div_zero,
    input  muldiv_op_t        i_fin_op,
    input  logic              i_fin_sign_a,
    input  logic              i_fin_sign_b,
    input  logic              i_fin_div_zero,
    input  logic [2*XLEN-1:0] i_fin_acc,
    output logic [XLEN-1:0]   o_fin_result
);

    logic              w_neg;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;

    // MUL and MULHU are handled as unsigned: the low half of a product is
    // independent of operand signedness.
    assign o_sign_a   = i_a[XLEN-1] & (i_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    assign o_sign_b   = i_b[XLEN-1] & (i_op inside {OP_MULH, OP_DIV, OP_REM});
    assign o_abs_a    = o_sign_a ? (~i_a + 1'b1) : i_a;
    assign o_abs_b    = o_sign_b ? (~i_b + 1'b1) : i_b;
    assign o_div_zero = is_div(i_op) && (i_b == '0);

    assign w_neg  = i_fin_sign_a ^ i_fin_sign_b;
    assign w_prod = w_neg ? (~i_fin_acc + 1'b1) : i_fin_acc;
    assign w_quo  = i_fin_acc[XLEN-1:0];
    assign w_rem  = i_fin_acc[2*XLEN-1:XLEN];

    always_comb begin
        o_fin_result = '0;
        case (i_fin_op)
            OP_MUL:                       o_fin_result = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: o_fin_result = w_prod[2*XLEN-1:XLEN];
            // A zero divisor yields an all-ones magnitude from the restoring
            // loop; the quotient must stay all-ones regardless of sign.
            OP_DIV, OP_DIVU:              o_fin_result = i_fin_div_zero ? '1 :
                                                         (w_neg ? (~w_quo + 1'b1) : w_quo);
            default:                      o_fin_result = i_fin_sign_a ? (~w_rem + 1'b1) : w_rem;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_alu.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_alu
// Purpose  : Iterative RV32M multiply/divide unit. Radix-2 shift-add
//            multiplier and restoring divider, XLEN iterations each, with
//            valid/ready handshakes on both sides and a synchronous kill.
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready, op, A, B   request
//            kill                          flush, abandons any operation
//            out_valid/out_ready, Result, DivZero   response
// Options  : MULDIV_EARLY_OUT_EN - resolve divide-by-zero, signed overflow
//            and multiply-by-zero on the accept edge (out_valid in cycle 1).
// Revision : 1.0  initial release
// ============================================================================
module muldiv_alu
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OPW  = 3
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result,
    output logic            DivZero
);

    localparam int                 c_cnt_w = cnt_width(XLEN);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(XLEN - 1);

    muldiv_state_t     r_state;
    muldiv_op_t        r_op;
    logic              r_sign_a;
    logic              r_sign_b;
    logic              r_dz;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_mcand;
    logic [c_cnt_w-1:0] r_cnt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_result;
    logic              r_divzero;

    muldiv_op_t        w_op;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_sign_a;
    logic              w_sign_b;
    logic              w_in_dz;
    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_acc_next;
    logic [XLEN-1:0]   w_final;

    assign w_op      = muldiv_op_t'(op);
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign Result    = r_result;
    assign DivZero   = r_divzero;

    muldiv_signfix #(.XLEN(XLEN)) u_signfix (
        .i_op           (w_op),
        .i_a            (A),
        .i_b            (B),
        .o_abs_a        (w_abs_a),
        .o_abs_b        (w_abs_b),
        .o_sign_a       (w_sign_a),
        .o_sign_b       (w_sign_b),
        .o_div_zero     (w_in_dz),
        .i_fin_op       (r_op),
        .i_fin_sign_a   (r_sign_a),
        .i_fin_sign_b   (r_sign_b),
        .i_fin_div_zero (r_dz),
        .i_fin_acc      (w_acc_next),
        .o_fin_result   (w_final)
    );

    // Accumulator layout: multiply keeps {partial product, multiplier} and
    // shifts right; divide keeps {remainder, dividend/quotient} and shifts
    // left, inserting one quotient bit per cycle.
    assign w_hi    = r_acc[2*XLEN-1:XLEN];
    assign w_lo    = r_acc[XLEN-1:0];
    assign w_sum   = {1'b0, w_hi} + ({1'b0, r_mcand} & {(XLEN+1){w_lo[0]}});
    assign w_shift = {w_hi, w_lo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_mcand};

    always_comb begin
        w_acc_next = {w_sum, w_lo[XLEN-1:1]};
        if (is_div(r_op)) begin
            // Remainder stays below the divisor, so a borrow shows in the MSB.
            if (!w_diff[XLEN]) begin
                w_acc_next = {w_diff[XLEN-1:0], w_lo[XLEN-2:0], 1'b1};
            end else begin
                w_acc_next = {w_shift[XLEN-1:0], w_lo[XLEN-2:0], 1'b0};
            end
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            w_ovf;
    logic            w_mul_zero;
    logic            w_early;
    logic [XLEN-1:0] w_early_result;

    assign w_ovf      = (w_op inside {OP_DIV, OP_REM}) &&
                        (A == {1'b1, {(XLEN-1){1'b0}}}) && (&B);
    assign w_mul_zero = !is_div(w_op) && ((A == '0) || (B == '0));
    assign w_early    = w_in_dz || w_ovf || w_mul_zero;

    // Overflow quotient is the most-negative value, which is A itself.
    always_comb begin
        w_early_result = '0;
        case (w_op)
            OP_DIV, OP_DIVU: w_early_result = w_in_dz ? '1 : A;
            OP_REM, OP_REMU: w_early_result = w_in_dz ? A : '0;
            default:         w_early_result = '0;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_MUL;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_dz        <= 1'b0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_divzero   <= 1'b0;
        end else if (kill) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_op     <= w_op;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_dz     <= w_in_dz;
                        r_cnt    <= '0;
                        if (is_div(w_op)) begin
                            r_acc   <= {{XLEN{1'b0}}, w_abs_a};
                            r_mcand <= w_abs_b;
                        end else begin
                            r_acc   <= {{XLEN{1'b0}}, w_abs_b};
                            r_mcand <= w_abs_a;
                        end
                        r_in_ready <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
                        if (w_early) begin
                            r_result    <= w_early_result;
                            r_divzero   <= w_in_dz;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_state <= ST_CALC;
                        end
`else
                        r_state <= ST_CALC;
`endif
                    end
                end
                ST_CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_result    <= w_final;
                        r_divzero   <= r_dz;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_alu
// Purpose  : Self-checking bench for muldiv_alu (XLEN=32). Expected results
//            are queued when a request is issued and compared when the unit
//            presents out_valid. Honours MULDIV_EARLY_OUT_EN for latency.
// Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_alu;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] Result;
    logic            DivZero;

    typedef struct {
        logic [31:0] res;
        logic        dz;
    } exp_t;

    typedef struct {
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    muldiv_alu #(.XLEN(XLEN), .OPW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (A),
        .B         (B),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .DivZero   (DivZero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Independent reference using 64-bit host arithmetic.
    function automatic logic [32:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa_l;
        longint      sb_l;
        longint      ub_l;
        longint      t;
        logic [63:0] p;
        logic [31:0] r;
        logic        dz;
        sa_l = $signed(a);
        sb_l = $signed(b);
        ub_l = longint'({32'd0, b});
        dz   = 1'b0;
        r    = '0;
        case (o)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
            3'd1: begin t = sa_l * sb_l; p = t; r = p[63:32]; end
            3'd2: begin t = sa_l * ub_l; p = t; r = p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            3'd4: if (b == 0) begin r = '1; dz = 1'b1; end
                  else begin t = sa_l / sb_l; p = t; r = p[31:0]; end
            3'd5: if (b == 0) begin r = '1; dz = 1'b1; end
                  else r = a / b;
            3'd6: if (b == 0) begin r = a; dz = 1'b1; end
                  else begin t = sa_l % sb_l; p = t; r = p[31:0]; end
            default: if (b == 0) begin r = a; dz = 1'b1; end
                     else r = a % b;
        endcase
        return {dz, r};
    endfunction

    function automatic bit early_case(input logic [2:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
        if (o[2])
            return (b == 0) || (((o == 3'd4) || (o == 3'd6)) &&
                                (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
        return (a == 0) || (b == 0);
    endfunction

    function automatic int exp_latency(input logic [2:0] o, input logic [31:0] a,
                                       input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (early_case(o, a, b)) return 1;
`else
        if (early_case(o, a, b)) return XLEN + 1;
`endif
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check_eq("ready_timeout", in_ready, 1);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        wait_ready();
        op       = o;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the accept edge.
    task automatic wait_valid(output int lat, output logic busy_rdy);
        lat      = 1;
        busy_rdy = in_ready;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (in_ready) busy_rdy = 1'b1;
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic edz, input int hold,
                          input string tag);
        exp_t        e;
        int          lat;
        logic        busy;
        logic        bad;
        logic [31:0] held;
        e.res = er;
        e.dz  = edz;
        sb_q.push_back(e);
        out_ready = (hold == 0);
        issue(o, a, b);
        wait_valid(lat, busy);
        check_eq({tag, "/latency"}, 64'(lat), 64'(exp_latency(o, a, b)));
        check_eq({tag, "/in_ready_busy"}, busy, 0);
        if (out_valid) begin
            e = sb_q.pop_front();
            check_eq({tag, "/result"}, Result, e.res);
            check_eq({tag, "/divzero"}, DivZero, e.dz);
            if (hold > 0) begin
                held     = Result;
                bad      = 1'b0;
                op       = 3'd0;
                A        = 32'd3;
                B        = 32'd5;
                in_valid = 1'b1;
                repeat (hold) begin
                    @(posedge clk); #1;
                    if (!out_valid || Result !== held || in_ready) bad = 1'b1;
                end
                in_valid = 1'b0;
                check_eq({tag, "/bp_stable"}, bad, 0);
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            check_eq({tag, "/released"}, out_valid, 0);
            check_eq({tag, "/retained"}, Result, e.res);
        end else begin
            check_eq({tag, "/out_valid_timeout"}, out_valid, 1);
            e = sb_q.pop_front();
        end
        out_ready = 1'b1;
    endtask

    initial begin
        vec_t        dir[22];
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [32:0] m;
        int          lat;
        logic        busy;
        logic        seen;

        dir[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        dir[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0};
        dir[2]  = '{3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0};
        dir[3]  = '{3'd2, 32'h8000_0000,  32'h8000_0000, 32'hC000_0000, 1'b0};
        dir[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
        dir[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0};
        dir[6]  = '{3'd5, 32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF, 1'b0};
        dir[7]  = '{3'd5, 32'h0000_1234,  32'd0,         32'hFFFF_FFFF, 1'b1};
        dir[8]  = '{3'd7, 32'h0000_1234,  32'd0,         32'h0000_1234, 1'b1};
        dir[9]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
        dir[10] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        dir[11] = '{3'd4, 32'h0000_1234,  32'd0,         32'hFFFF_FFFF, 1'b1};
        dir[12] = '{3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 1'b1};
        dir[13] = '{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1'b1};
        dir[14] = '{3'd0, 32'd0,          32'd12345,     32'h0000_0000, 1'b0};
        dir[15] = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
        dir[16] = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        dir[17] = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        dir[18] = '{3'd5, 32'd100,        32'd7,         32'h0000_000E, 1'b0};
        dir[19] = '{3'd7, 32'd100,        32'd7,         32'h0000_0002, 1'b0};
        dir[20] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
        dir[21] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'd0;
        A         = '0;
        B         = '0;
        kill      = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset/in_ready",  in_ready,  1);
        check_eq("reset/out_valid", out_valid, 0);
        check_eq("reset/result",    Result,    0);
        check_eq("reset/divzero",   DivZero,   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (dir[i])
            run_op(dir[i].o, dir[i].a, dir[i].b, dir[i].r, dir[i].dz, 0,
                   $sformatf("dir%0d", i));

        // Backpressure: out_ready low for 5 cycles in DONE with a pending request.
        run_op(3'd0, 32'd3, 32'd5, 32'd15, 1'b0, 5, "backpressure");

        // Kill in CALC cycle 10.
        issue(3'd0, 32'd5, 32'd6);
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check_eq("kill_calc/in_ready",  in_ready,  1);
        check_eq("kill_calc/out_valid", out_valid, 0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check_eq("kill_calc/no_result", seen, 0);

        // Kill and in_valid together in IDLE: no accept.
        op       = 3'd4;
        A        = 32'd9;
        B        = 32'd0;
        in_valid = 1'b1;
        kill     = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        kill     = 1'b0;
        check_eq("kill_idle/in_ready", in_ready, 1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check_eq("kill_idle/no_result", seen, 0);

        // Kill in DONE coinciding with out_ready.
        out_ready = 1'b0;
        issue(3'd0, 32'd9, 32'd9);
        wait_valid(lat, busy);
        check_eq("kill_done/valid_before", out_valid, 1);
        kill      = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check_eq("kill_done/out_valid", out_valid, 0);
        check_eq("kill_done/in_ready",  in_ready,  1);

        // Leave a nonzero Result/DivZero, then reset mid-CALC.
        run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 0, "pre_reset");
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid/in_ready",  in_ready,  1);
        check_eq("rst_mid/out_valid", out_valid, 0);
        check_eq("rst_mid/result",    Result,    0);
        check_eq("rst_mid/divzero",   DivZero,   0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check_eq("rst_mid/no_result", seen, 0);

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
            m  = ref_model(ro, ra, rb);
            run_op(ro, ra, rb, m[31:0], m[32], 0, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
